// File: rtl/timer_tick_sequencer.sv
// timer_tick_sequencer: Avalon-MM master driving a 16-bit interval timer.
// Programs period, services timeouts as ticks, and takes counter snapshots.
module timer_tick_sequencer #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'h0000C34F,
  parameter logic [3:0]  CTRL_RUN       = 4'h7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cfg_period,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic        snap_req,
  output logic [3:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        timer_irq,
  output logic        running,
  output logic        busy,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [31:0] snap_value,
  output logic        snap_valid
);

  localparam logic [15:0] CTRL_STOP = 16'h0008;

  localparam logic [3:0] A_STATUS = 4'd0;
  localparam logic [3:0] A_CTRL   = 4'd1;
  localparam logic [3:0] A_PERL   = 4'd2;
  localparam logic [3:0] A_PERH   = 4'd3;
  localparam logic [3:0] A_PER2   = 4'd4;
  localparam logic [3:0] A_PER3   = 4'd5;
  localparam logic [3:0] A_SNAPL  = 4'd6;
  localparam logic [3:0] A_SNAPH  = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_STOP_WR,
    S_PER0,
    S_PER1,
    S_PER2,
    S_PER3,
    S_CTRL_WR,
    S_RUN,
    S_ACK,
    S_SNAP_WR,
    S_SNAP_LO,
    S_SNAP_HI,
    S_SNAP_DONE,
    S_HALT_WR
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [31:0] period_q;
  logic [15:0] snap_lo;
  logic        snap_pend;

  // Next-state selection; stop beats start beats irq beats snapshot.
  always_comb begin
    nxt = state;
    if (state == S_IDLE) begin
      if (cfg_start && !cfg_stop)
        nxt = S_STOP_WR;
    end else if (state == S_HALT_WR) begin
      nxt = S_IDLE;
    end else if (cfg_stop) begin
      nxt = S_HALT_WR;
    end else if (cfg_start) begin
      nxt = S_STOP_WR;
    end else begin
      case (state)
        S_STOP_WR:   nxt = S_PER0;
        S_PER0:      nxt = S_PER1;
        S_PER1:      nxt = S_PER2;
        S_PER2:      nxt = S_PER3;
        S_PER3:      nxt = S_CTRL_WR;
        S_CTRL_WR:   nxt = S_RUN;
        S_RUN: begin
          if (timer_irq)
            nxt = S_ACK;
          else if (snap_pend || snap_req)
            nxt = S_SNAP_WR;
        end
        S_ACK:       nxt = S_RUN;
        S_SNAP_WR:   nxt = S_SNAP_LO;
        S_SNAP_LO:   nxt = S_SNAP_HI;
        S_SNAP_HI:   nxt = S_SNAP_DONE;
        S_SNAP_DONE: nxt = S_RUN;
        default:     nxt = S_IDLE;
      endcase
    end
  end

  // State, registered bus cycle for the entered state, and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      period_q       <= '0;
      snap_lo        <= '0;
      snap_pend      <= 1'b0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      running        <= 1'b0;
      busy           <= 1'b0;
      tick           <= 1'b0;
      tick_count     <= '0;
      snap_value     <= '0;
      snap_valid     <= 1'b0;
    end else begin
      state <= nxt;

      if (nxt == S_STOP_WR)
        period_q <= (cfg_period == 32'd0) ? DEFAULT_PERIOD : cfg_period;

      if (state == S_IDLE)
        snap_pend <= 1'b0;
      else if (nxt == S_SNAP_WR)
        snap_pend <= 1'b0;
      else if (snap_req)
        snap_pend <= 1'b1;

      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      case (nxt)
        S_STOP_WR, S_HALT_WR: begin
          avm_address    <= A_CTRL;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_writedata  <= CTRL_STOP;
        end
        S_PER0: begin
          avm_address    <= A_PERL;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_writedata  <= period_q[15:0];
        end
        S_PER1: begin
          avm_address    <= A_PERH;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_writedata  <= period_q[31:16];
        end
        S_PER2: begin
          avm_address    <= A_PER2;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
        end
        S_PER3: begin
          avm_address    <= A_PER3;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
        end
        S_CTRL_WR: begin
          avm_address    <= A_CTRL;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_writedata  <= {12'b0, CTRL_RUN};
        end
        S_ACK: begin
          avm_address    <= A_STATUS;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
        end
        S_SNAP_WR: begin
          avm_address    <= A_SNAPL;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
        end
        S_SNAP_LO: begin
          avm_address    <= A_SNAPL;
          avm_chipselect <= 1'b1;
        end
        S_SNAP_HI: begin
          avm_address    <= A_SNAPH;
          avm_chipselect <= 1'b1;
        end
        default: ;
      endcase

      if (nxt == S_STOP_WR || state == S_HALT_WR)
        running <= 1'b0;
      else if (state == S_CTRL_WR && nxt == S_RUN)
        running <= 1'b1;

      busy <= !(nxt == S_IDLE || nxt == S_RUN);

      tick <= (nxt == S_ACK);
      if (nxt == S_STOP_WR)
        tick_count <= '0;
      else if (nxt == S_ACK)
        tick_count <= tick_count + 32'd1;

      if (state == S_SNAP_HI)
        snap_lo <= avm_readdata;
      snap_valid <= (state == S_SNAP_DONE);
      if (state == S_SNAP_DONE)
        snap_value <= {avm_readdata, snap_lo};
    end
  end

endmodule

// File: tb/tb_timer_tick_sequencer.sv
// tb_timer_tick_sequencer: directed vectors plus a behavioural timer slave.
// Covers programming, tick service, snapshots, stop/start and reset.
module tb_timer_tick_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cfg_period = '0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic        snap_req = 1'b0;
  logic [3:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        timer_irq;
  logic        running;
  logic        busy;
  logic        tick;
  logic [31:0] tick_count;
  logic [31:0] snap_value;
  logic        snap_valid;

  int checks = 0;
  int errors = 0;

  timer_tick_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_period     (cfg_period),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .snap_req       (snap_req),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .timer_irq      (timer_irq),
    .running        (running),
    .busy           (busy),
    .tick           (tick),
    .tick_count     (tick_count),
    .snap_value     (snap_value),
    .snap_valid     (snap_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave model
  logic [15:0] p_lo, p_hi, rd;
  logic [31:0] cnt, snap;
  logic        t_run, t_ito, t_to;
  logic        hold = 1'b0;
  logic        load_req = 1'b0;
  logic [31:0] load_val = '0;

  assign avm_readdata = rd;
  assign timer_irq = t_to & t_ito;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_lo <= '0; p_hi <= '0; rd <= '0;
      cnt <= '0; snap <= '0;
      t_run <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0;
    end else begin
      rd <= '0;
      if (avm_chipselect && avm_write_n) begin
        if (avm_address == 4'd6) rd <= snap[15:0];
        if (avm_address == 4'd7) rd <= snap[31:16];
      end
      if (load_req)
        cnt <= load_val;
      else if (t_run && !hold) begin
        if (cnt == 32'd0) begin
          t_to <= 1'b1;
          cnt  <= {p_hi, p_lo};
        end else
          cnt <= cnt - 32'd1;
      end
      if (avm_chipselect && !avm_write_n) begin
        case (avm_address)
          4'd0: t_to <= 1'b0;
          4'd1: begin
            t_ito <= avm_writedata[0];
            if (avm_writedata[3])
              t_run <= 1'b0;
            else if (avm_writedata[2]) begin
              t_run <= 1'b1;
              cnt   <= {p_hi, p_lo};
            end
          end
          4'd2: p_lo <= avm_writedata;
          4'd3: p_hi <= avm_writedata;
          4'd6: snap <= cnt;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_irq();
    int n;
    n = 0;
    while (!timer_irq && n < 60) begin
      step();
      n++;
    end
    chk("irq_seen", 64'(timer_irq), 64'(1));
  endtask

  function automatic logic [23:0] bv(logic cs, logic wn, logic [3:0] a,
                                     logic [15:0] d, logic b, logic r);
    return {cs, wn, a, d, b, r};
  endfunction

  typedef struct {
    logic        start;
    logic        stop;
    logic        snap;
    logic [31:0] per;
    logic [23:0] exp;
  } vec_t;

  vec_t vt[16];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int prev_rise, nt, ns, ti, si;

    vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h9, bv(0, 1, 0, 16'h0, 0, 0)};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 32'h0, bv(1, 0, 1, 16'h8, 1, 0)};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0, bv(1, 0, 2, 16'h9, 1, 0)};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 32'h0, bv(1, 0, 3, 16'h0, 1, 0)};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0, bv(1, 0, 4, 16'h0, 1, 0)};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 32'h0, bv(1, 0, 5, 16'h0, 1, 0)};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h0, bv(1, 0, 1, 16'h7, 1, 0)};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h0, bv(0, 1, 0, 16'h0, 0, 1)};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0, bv(1, 0, 1, 16'h8, 1, 0)};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, bv(1, 0, 2, 16'hC34F, 1, 0)};
    vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0, bv(1, 0, 3, 16'h0, 1, 0)};
    vt[11] = '{1'b0, 1'b1, 1'b0, 32'h0, bv(1, 0, 4, 16'h0, 1, 0)};
    vt[12] = '{1'b0, 1'b0, 1'b0, 32'h0, bv(1, 0, 1, 16'h8, 1, 0)};
    vt[13] = '{1'b1, 1'b1, 1'b0, 32'h9, bv(0, 1, 0, 16'h0, 0, 0)};
    vt[14] = '{1'b0, 1'b0, 1'b1, 32'h0, bv(0, 1, 0, 16'h0, 0, 0)};
    vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0, bv(0, 1, 0, 16'h0, 0, 0)};

    // reset state
    step();
    step();
    chk("rst_bus", 64'({avm_chipselect, avm_write_n, avm_address,
        avm_writedata}), 64'({1'b0, 1'b1, 4'h0, 16'h0}));
    chk("rst_stat", 64'({running, busy, tick, snap_valid}), 64'(0));
    chk("rst_cnt", 64'({tick_count, snap_value}), 64'(0));
    reset_n = 1'b1;
    step();

    // table: program, restart with default period, stop in PER2
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("vec%0d", i), 64'({avm_chipselect, avm_write_n,
          avm_address, avm_writedata, busy, running}), 64'(vt[i].exp));
      cfg_start  = vt[i].start;
      cfg_stop   = vt[i].stop;
      snap_req   = vt[i].snap;
      cfg_period = vt[i].per;
      step();
    end
    cfg_start = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0;

    // run with period 9: three ticks 10 cycles apart
    cfg_period = 32'h9;
    cfg_start  = 1'b1;
    step();
    cfg_start = 1'b0;
    repeat (6) step();
    chk("run_up", 64'(running), 64'(1));
    prev_rise = 0;
    for (int k = 1; k <= 3; k++) begin
      wait_irq();
      if (k > 1)
        chk($sformatf("irq_gap%0d", k), 64'(cyc - prev_rise), 64'(10));
      prev_rise = cyc;
      step();
      chk($sformatf("ack%0d", k), 64'({avm_chipselect, avm_write_n,
          avm_address, tick}), 64'({1'b1, 1'b0, 4'h0, 1'b1}));
      chk($sformatf("tcnt%0d", k), 64'(tick_count), 64'(k));
      step();
      chk($sformatf("irq_low%0d", k), 64'({timer_irq, tick}), 64'(0));
    end

    // snapshot of a frozen counter
    hold = 1'b1;
    load_val = 32'h00012345;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("snap_wr", 64'({avm_chipselect, avm_write_n, avm_address, busy}),
        64'({1'b1, 1'b0, 4'h6, 1'b1}));
    step();
    chk("snap_lo", 64'({avm_chipselect, avm_write_n, avm_address}),
        64'({1'b1, 1'b1, 4'h6}));
    step();
    chk("snap_hi", 64'({avm_chipselect, avm_write_n, avm_address}),
        64'({1'b1, 1'b1, 4'h7}));
    step();
    chk("snap_done", 64'({avm_chipselect, snap_valid, busy}),
        64'({1'b0, 1'b0, 1'b1}));
    step();
    chk("snap_vld", 64'({snap_valid, busy}), 64'({1'b1, 1'b0}));
    chk("snap_val", 64'(snap_value), 64'(32'h00012345));
    step();
    chk("snap_pulse", 64'(snap_valid), 64'(0));

    // snap_req together with a rising irq: tick first, then snapshot
    hold = 1'b0;
    load_val = 32'd3;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    wait_irq();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("c_ack", 64'({avm_chipselect, avm_write_n, avm_address}),
        64'({1'b1, 1'b0, 4'h0}));
    nt = 0; ns = 0; ti = -1; si = -1;
    for (int i = 0; i < 9; i++) begin
      if (tick) begin
        nt++;
        if (ti < 0) ti = i;
      end
      if (snap_valid) begin
        ns++;
        si = i;
      end
      step();
    end
    chk("c_ticks", 64'(nt), 64'(1));
    chk("c_snaps", 64'(ns), 64'(1));
    chk("c_order", 64'(ti < si), 64'(1));
    chk("c_tcnt", 64'(tick_count), 64'(4));

    // service the pending irq, then restart clears tick_count
    step();
    step();
    chk("pre_restart", 64'({tick_count, timer_irq}), 64'({32'd5, 1'b0}));
    cfg_period = 32'h9;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("restart", 64'({tick_count, running, busy}),
        64'({32'd0, 1'b0, 1'b1}));
    repeat (6) step();
    chk("restart_run", 64'({running, busy}), 64'({1'b1, 1'b0}));
    wait_irq();
    step();
    chk("restart_tick", 64'({tick, tick_count}), 64'({1'b1, 32'd1}));
    step();

    // reset during SNAP_LO
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    step();
    chk("d_snap_lo", 64'({avm_chipselect, avm_write_n, avm_address}),
        64'({1'b1, 1'b1, 4'h6}));
    reset_n = 1'b0;
    #1;
    chk("d_bus", 64'({avm_chipselect, avm_write_n, avm_address,
        avm_writedata}), 64'({1'b0, 1'b1, 4'h0, 16'h0}));
    chk("d_stat", 64'({running, busy, tick, snap_valid}), 64'(0));
    chk("d_cnt", 64'({tick_count, snap_value}), 64'(0));
    #3;
    reset_n = 1'b1;
    nt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (snap_valid || busy || tick || avm_chipselect) nt++;
    end
    chk("d_quiet", 64'(nt), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
